// File: rtl/video_pattern_gen.sv
// Video test-pattern source producing a 24-bit {b,g,r} pixel stream with DE,
// HSYNC and VSYNC. It runs programmable line/frame timing counters and one of
// four selectable test patterns. All outputs are registered with one cycle of
// latency behind the counters.
module video_pattern_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int SYNC_POL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic [23:0] rgb_out,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = $clog2(BAR_W + 1);

  localparam logic            POL      = (SYNC_POL != 0);
  localparam logic [HW-1:0]   H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]   H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]   HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]   HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]   V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]   V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]   VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]   VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BW-1:0]   BAR_LAST = BW'(BAR_W - 1);

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_CHECKER = 2'd1,
    PAT_GRAY    = 2'd2,
    PAT_SOLID   = 2'd3
  } pattern_t;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [2:0]    bar_idx;
  logic [BW-1:0] bar_pix;
  pattern_t      pat_q;
  logic [23:0]   solid_q;

  logic          line_end;
  logic          frame_origin;
  logic          de;
  logic          hs;
  logic          vs;
  logic          h_bit5;
  logic          v_bit5;
  pattern_t      sel_eff;
  logic [23:0]   solid_eff;
  logic [23:0]   pix_rgb;

  // Position decode; at the frame origin the live pattern inputs are used so
  // a newly latched selection applies to pixel (0,0) itself
  always_comb begin
    line_end     = (h_cnt == H_LAST);
    frame_origin = (h_cnt == '0) && (v_cnt == '0);
    de           = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs           = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs           = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    h_bit5       = (h_cnt & HW'(32)) != '0;
    v_bit5       = (v_cnt & VW'(32)) != '0;
    sel_eff      = frame_origin ? pattern_t'(pattern_sel) : pat_q;
    solid_eff    = frame_origin ? solid_rgb : solid_q;
  end

  // Horizontal and vertical counters; idle forces them back to the origin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Colour-bar tracker: bar index follows h_cnt and saturates on the last bar
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_idx <= '0;
      bar_pix <= '0;
    end else if (!en || line_end) begin
      bar_idx <= '0;
      bar_pix <= '0;
    end else if (bar_pix == BAR_LAST) begin
      bar_pix <= '0;
      if (bar_idx != 3'd7) begin
        bar_idx <= bar_idx + 3'd1;
      end
    end else begin
      bar_pix <= bar_pix + BW'(1);
    end
  end

  // Pattern selection is captured only at the frame origin to avoid tearing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q   <= PAT_BARS;
      solid_q <= '0;
    end else if (frame_origin) begin
      pat_q   <= pattern_t'(pattern_sel);
      solid_q <= solid_rgb;
    end
  end

  // Pixel colour for the current counter position
  always_comb begin
    pix_rgb = '0;
    case (sel_eff)
      PAT_BARS: begin
        case (bar_idx)
          3'd0:    pix_rgb = 24'hFFFFFF;
          3'd1:    pix_rgb = 24'h00FFFF;
          3'd2:    pix_rgb = 24'hFFFF00;
          3'd3:    pix_rgb = 24'h00FF00;
          3'd4:    pix_rgb = 24'hFF00FF;
          3'd5:    pix_rgb = 24'h0000FF;
          3'd6:    pix_rgb = 24'hFF0000;
          default: pix_rgb = 24'h000000;
        endcase
      end
      PAT_CHECKER: pix_rgb = (h_bit5 ^ v_bit5) ? 24'hFFFFFF : 24'h000000;
      PAT_GRAY:    pix_rgb = {3{8'(h_cnt)}};
      PAT_SOLID:   pix_rgb = solid_eff;
      default:     pix_rgb = '0;
    endcase
  end

  // Registered outputs, one cycle behind the counters; idle drives blanking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_out     <= '0;
      de_out      <= 1'b0;
      hsync_out   <= ~POL;
      vsync_out   <= ~POL;
      frame_start <= 1'b0;
    end else if (!en) begin
      rgb_out     <= '0;
      de_out      <= 1'b0;
      hsync_out   <= ~POL;
      vsync_out   <= ~POL;
      frame_start <= 1'b0;
    end else begin
      rgb_out     <= de ? pix_rgb : '0;
      de_out      <= de;
      hsync_out   <= hs ? POL : ~POL;
      vsync_out   <= vs ? POL : ~POL;
      frame_start <= frame_origin;
    end
  end

endmodule
